// File: rtl/bm_pkg.sv
// Shared block-matching package: default widths, payload types, FSM states.
//   SAD_W_DFLT / RANGE_DFLT : defaults shared with the SAD processing element
//   sad_t / mv_t            : SAD value and signed motion-vector component
//   MV_MIN / MV_MAX         : displacement span -RANGE .. RANGE-1 at default range
package bm_pkg;

  localparam int unsigned SAD_W_DFLT = 12;
  localparam int unsigned RANGE_DFLT = 8;
  localparam int unsigned MV_W_DFLT  = $clog2(RANGE_DFLT) + 1;

  typedef logic [SAD_W_DFLT-1:0]        sad_t;
  typedef logic signed [MV_W_DFLT-1:0]  mv_t;

  localparam mv_t MV_MIN = mv_t'(-$signed(RANGE_DFLT));
  localparam mv_t MV_MAX = mv_t'(RANGE_DFLT - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

endpackage

// File: rtl/sad_min_select_if.sv
// Candidate SAD stream in, best motion vector out.
//   master : SAD producer / result consumer (drives start, sad_valid, sad)
//   slave  : sad_min_select (drives busy, mv_valid, best_dx, best_dy, best_sad)
interface sad_min_select_if #(
  parameter int unsigned SAD_W = 12,
  parameter int unsigned MV_W  = 4
) ();

  logic                    start;
  logic                    sad_valid;
  logic [SAD_W-1:0]        sad;
  logic                    busy;
  logic                    mv_valid;
  logic signed [MV_W-1:0]  best_dx;
  logic signed [MV_W-1:0]  best_dy;
  logic [SAD_W-1:0]        best_sad;

  modport master (
    output start, sad_valid, sad,
    input  busy, mv_valid, best_dx, best_dy, best_sad
  );

  modport slave (
    input  start, sad_valid, sad,
    output busy, mv_valid, best_dx, best_dy, best_sad
  );

endinterface

// File: rtl/mv_raster_counter.sv
// Raster-order (dx fastest) position counter over the search window.
//   clk, reset : clock, synchronous active-high reset
//   load       : reinitialise to (-RANGE, -RANGE)
//   advance    : step to the next candidate position
//   dx, dy     : current signed position
//   last       : current position is (RANGE-1, RANGE-1)
module mv_raster_counter
  import bm_pkg::*;
#(
  parameter int unsigned RANGE = RANGE_DFLT,
  parameter int unsigned MV_W  = $clog2(RANGE) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   advance,
  output logic signed [MV_W-1:0] dx,
  output logic signed [MV_W-1:0] dy,
  output logic                   last
);

  localparam logic signed [MV_W-1:0] MV_LO = MV_W'(-$signed(RANGE));
  localparam logic signed [MV_W-1:0] MV_HI = MV_W'(RANGE - 1);

  logic signed [MV_W-1:0] dx_q, dx_d;
  logic signed [MV_W-1:0] dy_q, dy_d;

  // Wrap is detected on RANGE-1, not on two's-complement overflow.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (load) begin
      dx_d = MV_LO;
      dy_d = MV_LO;
    end else if (advance) begin
      if (dx_q == MV_HI) begin
        dx_d = MV_LO;
        dy_d = dy_q + MV_W'(1);
      end else begin
        dx_d = dx_q + MV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= MV_LO;
      dy_q <= MV_LO;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == MV_HI) && (dy_q == MV_HI);

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD and its motion vector over one full-search window and
// emits a single (best_dx, best_dy, best_sad) result per reference block.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of sad_min_select_if (start/sad stream in, result out)
module sad_min_select
  import bm_pkg::*;
#(
  parameter int unsigned SAD_W = SAD_W_DFLT,
  parameter int unsigned RANGE = RANGE_DFLT,
  parameter int unsigned MV_W  = $clog2(RANGE) + 1
) (
  input  logic            clk,
  input  logic            reset,
  sad_min_select_if.slave bus
);

  localparam logic signed [MV_W-1:0] MV_LO = MV_W'(-$signed(RANGE));

  state_e state_q, state_d;

  logic [SAD_W-1:0]       min_q, min_d;
  logic signed [MV_W-1:0] mdx_q, mdx_d, mdy_q, mdy_d;
  logic [SAD_W-1:0]       best_sad_q, best_sad_d;
  logic signed [MV_W-1:0] best_dx_q, best_dx_d, best_dy_q, best_dy_d;
  logic                   mv_valid_q, mv_valid_d;
  logic                   busy_q, busy_d;

  logic                   accept_c, upd_c, done_c, last_c;
  logic signed [MV_W-1:0] dx_c, dy_c;

  mv_raster_counter #(
    .RANGE (RANGE),
    .MV_W  (MV_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.start),
    .advance (accept_c),
    .dx      (dx_c),
    .dy      (dy_c),
    .last    (last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start always (re)enters SEARCH; the last accepted candidate ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_SEARCH;
      ST_SEARCH: begin
        if (bus.start)   state_d = ST_SEARCH;
        else if (done_c) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath control. A SAD presented together with start is dropped.
  // Preloading the tracked position with (-RANGE,-RANGE) makes an all-ones
  // first SAD still report that position without a separate first flag.
  always_comb begin
    accept_c   = (state_q == ST_SEARCH) && bus.sad_valid && !bus.start;
    upd_c      = accept_c && (bus.sad < min_q);
    done_c     = accept_c && last_c;
    min_d      = min_q;
    mdx_d      = mdx_q;
    mdy_d      = mdy_q;
    best_sad_d = best_sad_q;
    best_dx_d  = best_dx_q;
    best_dy_d  = best_dy_q;
    mv_valid_d = done_c;
    busy_d     = (state_d == ST_SEARCH);

    if (bus.start) begin
      min_d = '1;
      mdx_d = MV_LO;
      mdy_d = MV_LO;
    end else if (upd_c) begin
      min_d = bus.sad;
      mdx_d = dx_c;
      mdy_d = dy_c;
    end

    // Final compare folded straight into the result registers.
    if (done_c) begin
      best_sad_d = upd_c ? bus.sad : min_q;
      best_dx_d  = upd_c ? dx_c    : mdx_q;
      best_dy_d  = upd_c ? dy_c    : mdy_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q      <= '1;
      mdx_q      <= MV_LO;
      mdy_q      <= MV_LO;
      best_sad_q <= '0;
      best_dx_q  <= '0;
      best_dy_q  <= '0;
      mv_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      min_q      <= min_d;
      mdx_q      <= mdx_d;
      mdy_q      <= mdy_d;
      best_sad_q <= best_sad_d;
      best_dx_q  <= best_dx_d;
      best_dy_q  <= best_dy_d;
      mv_valid_q <= mv_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.mv_valid = mv_valid_q;
  assign bus.best_dx  = best_dx_q;
  assign bus.best_dy  = best_dy_q;
  assign bus.best_sad = best_sad_q;

endmodule
